alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU: a WIDTH-bit integer ALU with valid/ready flow control, a registered output stage, status flags, and an iterative multi-cycle multiply. It sits between operand fetch and writeback in the datapath. For WIDTH=32 it is result-compatible with the legacy 3-bit opcode set on OPCode[2:0] when OPCode[3]=0; the legacy 33rd result bit is provided as Carry.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcodes, FSM states, flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    // Status bundle carried alongside the result in the output register.
    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic illegal;
    } flags_t;

    // Opcodes 12..15 are unused and produce an IllegalOp result.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b (unsigned).
// Latency: start at edge k, done asserted in the cycle before edge k+WIDTH (WIDTH steps).
// Backpressure: none; the caller only starts it when the result slot is guaranteed free.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH - 1);

    logic             active;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] addend;

    // Partial product for the current multiplier bit; the final step's sum is the product.
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = active && (cnt == LAST_STEP);

    // One multiplier bit consumed per cycle: multiplicand shifts left, multiplier right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with registered result/flags and an iterative multiply.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles after acceptance for MUL.
// Backpressure: result held while OutValid && !OutReady; InReady low then and during MUL.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic [3:0]       OPCode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Calc,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic             IllegalOp
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    flags_t           out_flags;
    flags_t           res_flags;
    logic [WIDTH-1:0] res_calc;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sra_res;
    logic             in_fire;
    logic             out_fire;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign InReady   = Reset_n && (state == S_IDLE) && (!OutValid || OutReady);
    assign in_fire   = InValid && InReady;
    assign out_fire  = OutValid && OutReady;
    assign mul_start = in_fire && (OPCode == OP_MUL);

    assign sum     = {1'b0, DataA} + {1'b0, DataB};
    assign diff    = {1'b0, DataA} - {1'b0, DataB};
    assign shamt   = DataB[SHW-1:0];
    assign sra_res = $signed(DataA) >>> shamt;

    assign Carry     = out_flags.carry;
    assign Zero      = out_flags.zero;
    assign Negative  = out_flags.negative;
    assign Overflow  = out_flags.overflow;
    assign IllegalOp = out_flags.illegal;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .start   (mul_start),
        .a       (DataA),
        .b       (DataB),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle op decode and flag generation; MUL results come from the multiplier.
    always_comb begin
        res_calc  = '0;
        res_flags = '0;
        case (OPCode)
            OP_ADD: begin
                res_calc           = sum[WIDTH-1:0];
                res_flags.carry    = sum[WIDTH];
                res_flags.overflow = (DataA[WIDTH-1] == DataB[WIDTH-1]) &&
                                     (sum[WIDTH-1] != DataA[WIDTH-1]);
            end
            OP_SUB: begin
                res_calc           = diff[WIDTH-1:0];
                res_flags.carry    = diff[WIDTH];
                res_flags.overflow = (DataA[WIDTH-1] != DataB[WIDTH-1]) &&
                                     (diff[WIDTH-1] != DataA[WIDTH-1]);
            end
            OP_AND:  res_calc = DataA & DataB;
            OP_OR:   res_calc = DataA | DataB;
            OP_NOR:  res_calc = ~(DataA | DataB);
            OP_XOR:  res_calc = DataA ^ DataB;
            OP_SLL:  res_calc = DataA << shamt;
            OP_SRL:  res_calc = DataA >> shamt;
            OP_SRA:  res_calc = sra_res;
            OP_SLT:  res_calc = {{(WIDTH-1){1'b0}}, ($signed(DataA) < $signed(DataB))};
            OP_SLTU: res_calc = {{(WIDTH-1){1'b0}}, (DataA < DataB)};
            OP_MUL:  res_calc = '0;
            default: res_flags.illegal = 1'b1;
        endcase
        if (op_legal(OPCode)) begin
            res_flags.zero     = (res_calc == '0);
            res_flags.negative = res_calc[WIDTH-1];
        end
    end

    // FSM and output register: loads on a single-cycle accept or multiply completion.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            OutValid  <= 1'b0;
            Calc      <= '0;
            out_flags <= '0;
        end else begin
            if (out_fire) begin
                OutValid <= 1'b0;
            end
            if (state == S_IDLE) begin
                if (mul_start) begin
                    state <= S_MUL;
                end else if (in_fire) begin
                    OutValid  <= 1'b1;
                    Calc      <= res_calc;
                    out_flags <= res_flags;
                end
            end else if (mul_done) begin
                state              <= S_IDLE;
                OutValid           <= 1'b1;
                Calc               <= mul_product;
                out_flags          <= '0;
                out_flags.zero     <= (mul_product == '0);
                out_flags.negative <= mul_product[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    typedef struct {
        logic [31:0] calc;
        logic [4:0]  fl;   // {carry, zero, negative, overflow, illegal}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, calc;
    logic [3:0]  op;
    logic        carry, zero, neg, ovf, ill;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, calc8;
    logic [3:0]  op8;
    logic        carry8, zero8, neg8, ovf8, ill8;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    bit          held = 1'b0;
    logic [36:0] held_v;
    bit          rnd_bp = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .Clock(clk), .Reset_n(rst_n), .InValid(in_valid), .InReady(in_ready),
        .DataA(a), .DataB(b), .OPCode(op), .OutValid(out_valid), .OutReady(out_ready),
        .Calc(calc), .Carry(carry), .Zero(zero), .Negative(neg), .Overflow(ovf),
        .IllegalOp(ill)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .Clock(clk), .Reset_n(rst_n), .InValid(in_valid8), .InReady(in_ready8),
        .DataA(a8), .DataB(b8), .OPCode(op8), .OutValid(out_valid8), .OutReady(out_ready8),
        .Calc(calc8), .Carry(carry8), .Zero(zero8), .Negative(neg8), .Overflow(ovf8),
        .IllegalOp(ill8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint unsigned ua = x, ub = y, r = 0, full;
        longint sa = $signed(x), sy = $signed(y), s;
        bit c = 0, v = 0, il = 0, z = 0, n = 0;
        int sh = int'(ub % 32);
        case (o)
            4'd0:  begin full = ua + ub; r = full; c = full[32]; s = sa + sy;
                         v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1:  begin r = ua - ub; c = ua < ub; s = sa - sy;
                         v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ~(ua | ub);
            4'd5:  r = ua ^ ub;
            4'd6:  r = ua << sh;
            4'd7:  r = ua >> sh;
            4'd8:  r = longint'(sa >>> sh);
            4'd9:  r = (sa < sy) ? 1 : 0;
            4'd10: r = (ua < ub) ? 1 : 0;
            4'd11: r = ua * ub;
            default: il = 1;
        endcase
        r = r & 64'hFFFF_FFFF;
        if (!il) begin
            z = (r == 0);
            n = r[31];
        end
        e.calc = r[31:0];
        e.fl   = {c, z, n, v, il};
        return e;
    endfunction

    // Present one operand bundle until accepted; the expected result is queued on acceptance.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit directed, input logic [31:0] ec, input logic [4:0] ef);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        if (directed) begin
            e.calc = ec;
            e.fl   = ef;
        end else begin
            e = model(o, x, y);
        end
        in_valid = 1'b1; op = o; a = x; b = y;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end else if (++n > 200) begin
                check("issue_timeout", 0, 1);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop and compare on every consumed result; check stall behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_value", {calc, carry, zero, neg, ovf, ill}, held_v);
            end
            if (out_valid && !out_ready) check("stall_inready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("calc", calc, e.calc);
                    check("flags", {carry, zero, neg, ovf, ill}, e.fl);
                end
            end
            held   = out_valid && !out_ready;
            held_v = {calc, carry, zero, neg, ovf, ill};
        end else begin
            held = 1'b0;
        end
    end

    // Random output backpressure, enabled only for the random phase.
    initial forever begin
        @(posedge clk); #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        rst_n = 1'b0; in_valid = 0; a = 0; b = 0; op = 0; out_ready = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; op8 = 0; out_ready8 = 1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_outvalid", out_valid, 0);
        check("rst_calc", calc, 0);
        check("rst_flags", {carry, zero, neg, ovf, ill}, 0);
        check("rst_inready", in_ready, 0);
        check("rst_outvalid8", out_valid8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_inready", in_ready, 1);

        // Directed results, streamed back to back
        issue(4'd0,  32'hFFFF_FFFF, 32'h1,  1, 32'h0,         5'b11000);
        issue(4'd0,  32'h7FFF_FFFF, 32'h1,  1, 32'h8000_0000, 5'b00110);
        issue(4'd1,  32'd3,         32'd5,  1, 32'hFFFF_FFFE, 5'b10100);
        issue(4'd9,  32'hFFFF_FFFF, 32'h1,  1, 32'h1,         5'b00000);
        issue(4'd10, 32'hFFFF_FFFF, 32'h1,  1, 32'h0,         5'b01000);
        issue(4'd8,  32'h8000_0000, 32'h21, 1, 32'hC000_0000, 5'b00100);
        issue(4'd13, 32'd5,         32'd7,  1, 32'h0,         5'b00001);
        issue(4'd3,  32'd1,         32'd2,  1, 32'h3,         5'b00000);
        issue(4'd11, 32'h1_0000,    32'h1_0001, 1, 32'h1_0000, 5'b00000);
        issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h1,  5'b00000);
        drain();

        // WIDTH=8 multiply latency and a single-cycle op
        @(posedge clk); #1;
        in_valid8 = 1; op8 = 4'd11; a8 = 8'd13; b8 = 8'd11;
        @(negedge clk);
        check("mul8_inready_pre", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("mul8_busy_inready", in_ready8, 0);
            check("mul8_busy_outvalid", out_valid8, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("mul8_outvalid", out_valid8, 1);
        check("mul8_calc", calc8, 8'h8F);
        check("mul8_flags", {carry8, zero8, neg8, ovf8, ill8}, 5'b00100);
        check("mul8_inready_post", in_ready8, 1);
        in_valid8 = 1; op8 = 4'd0; a8 = 8'd200; b8 = 8'd100;
        @(posedge clk); #1;
        in_valid8 = 0;
        @(negedge clk);
        check("add8_outvalid", out_valid8, 1);
        check("add8_calc", calc8, 8'h2C);
        check("add8_flags", {carry8, zero8, neg8, ovf8, ill8}, 5'b10000);
        @(posedge clk); #1;
        @(negedge clk);
        check("add8_consumed", out_valid8, 0);

        // Backpressure: 4 ADDs, OutReady low for 3 cycles after the first result
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) issue(4'd0, $urandom, $urandom, 0, 0, 0);
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("bp_first_seen", out_valid, 1);
                out_ready = 0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();

        // Reset in the middle of a multiply
        issue(4'd11, 32'h1234, 32'h5678, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul_rst_outvalid", out_valid, 0);
        check("midmul_rst_calc", calc, 0);
        check("midmul_rst_flags", {carry, zero, neg, ovf, ill}, 0);
        check("midmul_rst_inready", in_ready, 0);
        sb.delete();
        @(posedge clk); #1;
        check("midmul_rst_inready_hold", in_ready, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd0, 32'd10, 32'd20, 1, 32'd30, 5'b00000);
        drain();

        // Random ops with random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            issue(o, pick(), pick(), 0, 0, 0);
        end
        rnd_bp = 1'b0;
        @(posedge clk); #1;
        out_ready = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
